// File: rtl/config_pkg.sv
// Shared core configuration and PMA table types.
// range_check is the single definition of the region match equation.
package config_pkg;

    localparam int unsigned NrMaxRules = 16;

    typedef struct packed {
        int unsigned NrPMAEntries;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    typedef struct packed {
        logic nonidem;
        logic exec;
        logic cached;
    } pma_attr_t;

    typedef struct packed {
        logic       valid;
        logic       lock;
        logic [63:0] base;
        logic [63:0] len;
        pma_attr_t  attr;
    } pma_entry_t;

    // One extra bit on the upper bound so a region ending at 2^64 does not wrap.
    function automatic logic range_check(input logic [63:0] base, input logic [63:0] len,
                                         input logic [63:0] addr);
        logic [64:0] top;
        top = {1'b0, base} + {1'b0, len};
        return (base <= addr) && ({1'b0, addr} < top);
    endfunction

endpackage

// File: rtl/pma_range_match.sv
// Combinational match of one PMA entry against one lookup address.
module pma_range_match
    import config_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  pma_entry_t           entry,
    input  logic [AddrWidth-1:0] addr,
    output logic                 match
);

    // Entry fields are 64 bits; only the low AddrWidth bits take part.
    localparam logic [63:0] Mask = {64{1'b1}} >> (64 - AddrWidth);

    logic unusedFields;
    assign unusedFields = ^{entry.lock, entry.attr};

    assign match = entry.valid && range_check(entry.base & Mask, entry.len & Mask, 64'(addr));

endmodule

// File: rtl/pma_region_checker.sv
// Programmable PMA region table with a registered, one-cycle lookup.
// Lowest matching index wins; locked entries reject writes until reset.
module pma_region_checker
    import config_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
    parameter int unsigned NrRules     = 8,
    parameter int unsigned AddrWidth   = 64,
    parameter pma_attr_t   DefaultAttr = '0,
    localparam int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output pma_attr_t            resp_attr_o,
    output logic                 resp_hit_o,
    output logic [IdxW-1:0]      resp_idx_o,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  pma_entry_t           cfg_entry_i,
    output logic                 cfg_err_o
);

    if (NrRules < 1 || NrRules > NrMaxRules) begin : gen_bad_nr_rules
        $error("pma_region_checker: NrRules out of range");
    end
    if (AddrWidth < 1 || AddrWidth > 64) begin : gen_bad_addr_width
        $error("pma_region_checker: AddrWidth must be 1..64");
    end
    if (CVA6Cfg.NrPMAEntries != 0 && NrRules > CVA6Cfg.NrPMAEntries) begin : gen_bad_cfg
        $error("pma_region_checker: NrRules exceeds core configuration");
    end

    pma_entry_t       entries [NrRules];
    logic [NrRules-1:0] matchVec;

    for (genvar k = 0; k < NrRules; k++) begin : gen_match
        pma_range_match #(.AddrWidth(AddrWidth)) u_match (
            .entry (entries[k]),
            .addr  (req_addr_i),
            .match (matchVec[k])
        );
    end

    // Priority encoder: scan downward so the lowest matching index is last to write.
    logic            lkHit;
    logic [IdxW-1:0] lkIdx;
    pma_attr_t       lkAttr;

    always_comb begin
        lkHit  = 1'b0;
        lkIdx  = '0;
        lkAttr = DefaultAttr;
        for (int k = int'(NrRules) - 1; k >= 0; k--) begin
            if (matchVec[k]) begin
                lkHit  = 1'b1;
                lkIdx  = IdxW'(k);
                lkAttr = entries[k].attr;
            end
        end
    end

    // Write path; the lock lookup loops over valid indices so an out-of-range idx never indexes the table.
    logic idxInRange, wrLocked, wrAccept, wrReject;

    assign idxInRange = {1'b0, cfg_idx_i} < (IdxW + 1)'(NrRules);

    always_comb begin
        wrLocked = 1'b0;
        for (int k = 0; k < int'(NrRules); k++) begin
            if (cfg_idx_i == IdxW'(k)) wrLocked = entries[k].lock;
        end
    end

    assign wrAccept = cfg_we_i && idxInRange && !wrLocked;
    assign wrReject = cfg_we_i && !wrAccept;

    logic cfgErr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NrRules); k++) entries[k] <= '0;
            cfgErr <= 1'b0;
        end else begin
            cfgErr <= wrReject;
            for (int k = 0; k < int'(NrRules); k++) begin
                if (wrAccept && cfg_idx_i == IdxW'(k)) entries[k] <= cfg_entry_i;
            end
        end
    end

    // Response register: captured only on an accepted request, held while stalled.
    logic            respValid, respHit;
    logic [IdxW-1:0] respIdx;
    pma_attr_t       respAttr;
    logic            reqFire;

    assign req_ready_o = !respValid || resp_ready_i;
    assign reqFire     = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            respValid <= 1'b0;
            respHit   <= 1'b0;
            respIdx   <= '0;
            respAttr  <= DefaultAttr;
        end else if (reqFire) begin
            respValid <= 1'b1;
            respHit   <= lkHit;
            respIdx   <= lkIdx;
            respAttr  <= lkAttr;
        end else if (resp_ready_i) begin
            respValid <= 1'b0;
        end
    end

    assign resp_valid_o = respValid;
    assign resp_hit_o   = respHit;
    assign resp_idx_o   = respIdx;
    assign resp_attr_o  = respAttr;
    assign cfg_err_o    = cfgErr;

endmodule

// File: tb/tb_pma_region_checker.sv
// Bench for pma_region_checker: vector table plus scoreboard queue of expected responses.
module tb_pma_region_checker;
    import config_pkg::*;

    localparam int unsigned NR = 6;
    localparam int unsigned AW = 64;
    localparam int unsigned IW = 3;
    localparam pma_attr_t   DEF = pma_attr_t'(3'b100);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr = '0;
    logic          resp_valid_o;
    logic          resp_ready = 1'b1;
    pma_attr_t     resp_attr_o;
    logic          resp_hit_o;
    logic [IW-1:0] resp_idx_o;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    pma_entry_t    cfg_entry = '0;
    logic          cfg_err_o;

    pma_region_checker #(
        .CVA6Cfg(cva6_cfg_empty), .NrRules(NR), .AddrWidth(AW), .DefaultAttr(DEF)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .resp_attr_o(resp_attr_o),
        .resp_hit_o(resp_hit_o), .resp_idx_o(resp_idx_o),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_entry_i(cfg_entry), .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
        pma_attr_t     attr;
        int            issue;
        bit            chkLat;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [63:0]   addr;
        logic          hit;
        logic [IW-1:0] idx;
        logic [2:0]    attr;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pma_entry_t mk(input logic v, input logic l, input logic [63:0] b,
                                      input logic [63:0] n, input logic [2:0] at);
        pma_entry_t e;
        e.valid = v; e.lock = l; e.base = b; e.len = n; e.attr = pma_attr_t'(at);
        return e;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic h, input logic [IW-1:0] i,
                         input logic [2:0] at, input bit lat);
        exp_t e;
        req_valid = 1'b1;
        req_addr  = a;
        e.hit = h; e.idx = i; e.attr = pma_attr_t'(at); e.issue = cyc; e.chkLat = lat;
        q.push_back(e);
    endtask

    task automatic lookup(input logic [63:0] a, input logic h, input logic [IW-1:0] i,
                          input logic [2:0] at);
        drive(a, h, i, at, 1'b1);
        step();
        req_valid = 1'b0;
        step();
    endtask

    task automatic cfgWrite(input logic [IW-1:0] idx, input pma_entry_t ent, input logic expErr,
                            input string name);
        cfg_we = 1'b1; cfg_idx = idx; cfg_entry = ent;
        step();
        cfg_we = 1'b0;
        check({name, "_err"}, 64'(cfg_err_o), 64'(expErr));
        step();
        check({name, "_err_clr"}, 64'(cfg_err_o), 64'd0);
    endtask

    // Scoreboard: every completed response handshake pops one expectation.
    exp_t mon;
    always @(negedge clk) begin
        if (!rst && resp_valid_o && resp_ready) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon = q.pop_front();
                check("resp_hit", 64'(resp_hit_o), 64'(mon.hit));
                check("resp_idx", 64'(resp_idx_o), 64'(mon.idx));
                check("resp_attr", 64'(resp_attr_o), 64'(mon.attr));
                if (mon.chkLat) check("resp_latency", 64'(cyc), 64'(mon.issue + 1));
            end
        end
    end

    initial begin
        vecs[0]  = '{64'h8000_0FFF,            1'b1, 3'd0, 3'b010};
        vecs[1]  = '{64'h8000_1000,            1'b0, 3'd0, 3'b100};
        vecs[2]  = '{64'h8000_0000,            1'b1, 3'd0, 3'b010};
        vecs[3]  = '{64'h7FFF_FFFF,            1'b0, 3'd0, 3'b100};
        vecs[4]  = '{64'h1080,                 1'b1, 3'd2, 3'b001};
        vecs[5]  = '{64'h1800,                 1'b1, 3'd5, 3'b100};
        vecs[6]  = '{64'h10FF,                 1'b1, 3'd2, 3'b001};
        vecs[7]  = '{64'h1100,                 1'b1, 3'd5, 3'b100};
        vecs[8]  = '{64'h0FFF,                 1'b0, 3'd0, 3'b100};
        vecs[9]  = '{64'h2000,                 1'b0, 3'd0, 3'b100};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 3'd4, 3'b011};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_EFFF,  1'b0, 3'd0, 3'b100};
        vecs[12] = '{64'h5000,                 1'b0, 3'd0, 3'b100};
        vecs[13] = '{64'hFFFF_FFFF_FFFF_F000,  1'b1, 3'd4, 3'b011};

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_resp_hit", 64'(resp_hit_o), 64'd0);
        check("rst_resp_idx", 64'(resp_idx_o), 64'd0);
        check("rst_resp_attr", 64'(resp_attr_o), 64'(DEF));
        check("rst_cfg_err", 64'(cfg_err_o), 64'd0);
        rst = 1'b0;
        check("post_rst_ready", 64'(req_ready_o), 64'd1);
        step();

        cfgWrite(3'd0, mk(1, 0, 64'h8000_0000, 64'h1000, 3'b010), 1'b0, "w0");
        cfgWrite(3'd2, mk(1, 0, 64'h1000, 64'h100, 3'b001), 1'b0, "w2");
        cfgWrite(3'd5, mk(1, 0, 64'h1000, 64'h1000, 3'b100), 1'b0, "w5");
        cfgWrite(3'd4, mk(1, 0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b011), 1'b0, "w4");
        cfgWrite(3'd3, mk(1, 0, 64'h5000, 64'h0, 3'b010), 1'b0, "w3_len0");

        // Back-to-back lookups, one per cycle.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].addr, vecs[i].hit, vecs[i].idx, vecs[i].attr, 1'b1);
            step();
        end
        req_valid = 1'b0;
        step();

        // Lock, then rejected writes (locked entry, indices past the table).
        cfgWrite(3'd1, mk(1, 1, 64'h3000, 64'h100, 3'b010), 1'b0, "w1_lock");
        cfgWrite(3'd1, mk(1, 0, 64'h3000, 64'h100, 3'b001), 1'b1, "w1_locked");
        cfgWrite(3'd1, mk(0, 0, 64'h0, 64'h0, 3'b000), 1'b1, "w1_unlock");
        cfgWrite(3'd6, mk(1, 0, 64'h0, 64'h10000, 3'b001), 1'b1, "w_idx6");
        cfgWrite(3'd7, mk(1, 0, 64'h0, 64'h10000, 3'b001), 1'b1, "w_idx7");
        lookup(64'h3010, 1'b1, 3'd1, 3'b010);
        lookup(64'h0010, 1'b0, 3'd0, 3'b100);

        // Same-cycle write and lookup: old contents, then new.
        cfg_we = 1'b1; cfg_idx = 3'd3; cfg_entry = mk(1, 0, 64'h5000, 64'h100, 3'b010);
        drive(64'h5010, 1'b0, 3'd0, 3'b100, 1'b1);
        step();
        cfg_we = 1'b0;
        check("same_cycle_cfg_err", 64'(cfg_err_o), 64'd0);
        drive(64'h5010, 1'b1, 3'd3, 3'b010, 1'b1);
        step();
        req_valid = 1'b0;
        step();

        // Stall with a new request waiting, then reset in the middle of it.
        resp_ready = 1'b0;
        drive(64'h1080, 1'b1, 3'd2, 3'b001, 1'b0);
        step();
        req_addr = 64'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            check("stall_req_ready", 64'(req_ready_o), 64'd0);
            check("stall_valid", 64'(resp_valid_o), 64'd1);
            check("stall_hit", 64'(resp_hit_o), 64'd1);
            check("stall_idx", 64'(resp_idx_o), 64'd2);
            check("stall_attr", 64'(resp_attr_o), 64'(3'b001));
            step();
        end
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(resp_valid_o), 64'd0);
        check("rst_async_hit", 64'(resp_hit_o), 64'd0);
        check("rst_async_attr", 64'(resp_attr_o), 64'(DEF));
        q.delete();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("post_rst2_ready", 64'(req_ready_o), 64'd1);
        step();
        lookup(64'h1080, 1'b0, 3'd0, 3'b100);
        lookup(64'h3010, 1'b0, 3'd0, 3'b100);
        cfgWrite(3'd1, mk(1, 0, 64'h3000, 64'h100, 3'b001), 1'b0, "w1_after_rst");
        lookup(64'h3010, 1'b1, 3'd1, 3'b001);

        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pma_region_checker.md
PMA_REGION_CHECKER -- requirements
Module: pma_region_checker

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning the core configuration record.
REQ-002 SHALL have parameter NrRules, default 8, meaning the number of programmable regions (1..config_pkg::NrMaxRules).
REQ-003 SHALL have parameter AddrWidth, default 64, meaning the lookup/base/length width (≤64).
REQ-004 SHALL have parameter DefaultAttr, default '0, meaning the pma_attr_t returned on no match.
REQ-005 SHALL have clk_i  in  1  clock; single clock domain, all state on rising edge.
REQ-006 SHALL have rst_i  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have req_valid_i in 1, req_ready_o out 1, req_addr_i in AddrWidth: lookup request handshake.
REQ-008 SHALL have resp_valid_o out 1, resp_ready_i in 1, resp_attr_o out pma_attr_t, resp_hit_o out 1, resp_idx_o out $clog2(NrRules): lookup result.
REQ-009 SHALL have cfg_we_i in 1, cfg_idx_i in $clog2(NrRules), cfg_entry_i in pma_entry_t: table write port.
REQ-010 SHALL have cfg_err_o out 1: one-cycle pulse on a rejected write.

Function
REQ-011 Each entry SHALL hold valid, lock, base, len, attr {nonidem, exec, cached}.
REQ-012 Entry k SHALL match addr iff valid && base ≤ addr && {1'b0,addr} < base+len, evaluated at AddrWidth+1 bits; len=0 never matches.
REQ-013 On several matches, the lowest index SHALL win (priority, not OR); resp_idx_o = winning index, resp_hit_o=1, resp_attr_o = its attr.
REQ-014 On no match: resp_hit_o=0, resp_attr_o=DefaultAttr, resp_idx_o=0.
REQ-015 Lookup latency SHALL be exactly 1 cycle: a request accepted in cycle N yields resp_valid_o=1 in cycle N+1.
REQ-016 req_ready_o SHALL equal !resp_valid_o || resp_ready_i (single output register, no combinational path from req_addr_i to outputs).
REQ-017 While resp_valid_o=1 && resp_ready_i=0, all resp_* outputs SHALL hold stable.
REQ-018 Write accepted when cfg_we_i=1 && cfg_idx_i<NrRules && !entry.lock; the entry updates at the next edge.
REQ-019 Write to a locked entry or to idx≥NrRules SHALL leave the table unchanged and assert cfg_err_o the next cycle for one cycle.
REQ-020 Lock SHALL be sticky: once set, cleared only by rst_i.
REQ-021 A lookup and a write in the same cycle SHALL use the pre-write table contents (write visible to lookups from the next cycle).
REQ-022 Outputs SHALL not depend on req_addr_i when req_valid_i=0 (no capture).

Reset
REQ-023 rst_i asserted SHALL asynchronously clear all entries (valid=0, lock=0, base=0, len=0, attr=0), resp_valid_o=0, resp_hit_o=0, resp_idx_o=0, resp_attr_o=DefaultAttr, cfg_err_o=0.
REQ-024 A response pending at reset SHALL be dropped; req_ready_o=1 in the first cycle after reset deassertion.

Structure
REQ-025 pma_attr_t and pma_entry_t SHALL be defined in config_pkg; the match equation SHALL reuse config_pkg::range_check.
REQ-026 A combinational sub-module pma_range_match (one entry vs. one address -> match bit) SHALL be instantiated NrRules times; the priority encoder and registers live in pma_region_checker.
REQ-027 Elaboration SHALL assert NrRules in 1..NrMaxRules and AddrWidth ≤ 64.

Verification
REQ-028 Entry0 {base 0x8000_0000, len 0x1000, exec}; lookup 0x8000_0FFF -> hit, idx 0, exec=1; lookup 0x8000_1000 -> hit=0, attr=DefaultAttr.
REQ-029 Entries 2 {0x1000,0x100,cached} and 5 {0x1000,0x1000,nonidem}; lookup 0x1080 -> idx 2, cached only; lookup 0x1800 -> idx 5, nonidem.
REQ-030 Entry base 0xFFFF_FFFF_FFFF_F000, len 0x1000 (AddrWidth 64); lookup 0xFFFF_FFFF_FFFF_FFFF -> hit (no overflow).
REQ-031 Lock entry 1, then write entry 1 and idx=NrRules -> cfg_err_o pulses 1 cycle each, lookups show old contents.
REQ-032 Same-cycle write entry 3 and lookup in its range -> response uses old entry; following lookup uses new.
REQ-033 Hold resp_ready_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0, outputs stable; assert rst_i mid-stall -> resp_valid_o=0 immediately, table cleared.
